mod_register_file_mp: RTL and testbench

//  Parametrised multi-port register file for the MIPS core: two write ports (WB lane 0/1), NUM_RD combinational

---
 rtl/mod_register_file_mp.sv | 173 +++++++++++++++++
 tb/tb_mod_register_file_mp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_register_file_mp.sv
// Multi-port register file with two write lanes, NUM_RD combinational read ports,
// a sequential clear engine and a one-entry-per-cycle architectural dump stream.
module mod_register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clear_req,
    input  logic                     dump_req,
    output logic                     busy,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_nxt_s;
    logic                cnt_last_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                eff_we0_s;
    logic                eff_we1_s;
    logic [ADDR_W-1:0]   rd_addr_s [NUM_RD];
    logic [DATA_W-1:0]   rd_val_s  [NUM_RD];
    logic                dump_valid_r;
    logic                dump_done_r;
    logic [ADDR_W-1:0]   dump_addr_r;
    logic [DATA_W-1:0]   dump_data_r;

    // Effective write qualification; engine activity and hold both suppress writes.
    always_comb begin
        eff_we0_s = we0 & ~hold & (state_r == ST_IDLE)
                    & ~((ZERO_REG != 0) & (waddr0 == {ADDR_W{1'b0}}));
        eff_we1_s = we1 & ~hold & (state_r == ST_IDLE)
                    & ~((ZERO_REG != 0) & (waddr1 == {ADDR_W{1'b0}}));
        cnt_last_s = (cnt_r == {ADDR_W{1'b1}});
    end

    // Next-state logic for the clear/dump engine.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                end else if (dump_req) begin
                    state_nxt_s = ST_DUMP;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR, ST_DUMP: begin
                cnt_nxt_s = cnt_r + ADDR_W'(1'b1);
                if (cnt_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Engine state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Storage array; lane 1 is written last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else begin
            if (eff_we0_s) begin
                mem_r[waddr0] <= wdata0;
            end
            if (eff_we1_s) begin
                mem_r[waddr1] <= wdata1;
            end
        end
    end

    // Dump beat registers; address and data hold their last beat outside DUMP.
    always_ff @(posedge clk) begin
        if (reset) begin
            dump_valid_r <= 1'b0;
            dump_done_r  <= 1'b0;
            dump_addr_r  <= {ADDR_W{1'b0}};
            dump_data_r  <= {DATA_W{1'b0}};
        end else if (state_r == ST_DUMP) begin
            dump_valid_r <= 1'b1;
            dump_done_r  <= cnt_last_s;
            dump_addr_r  <= cnt_r;
            if ((ZERO_REG != 0) && (cnt_r == {ADDR_W{1'b0}})) begin
                dump_data_r <= {DATA_W{1'b0}};
            end else begin
                dump_data_r <= mem_r[cnt_r];
            end
        end else begin
            dump_valid_r <= 1'b0;
            dump_done_r  <= 1'b0;
        end
    end

    // Combinational read ports with optional forwarding of this cycle's writes.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k] = rd_addr[k*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (rd_addr_s[k] == {ADDR_W{1'b0}})) begin
                rd_val_s[k] = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && eff_we1_s && (waddr1 == rd_addr_s[k])) begin
                rd_val_s[k] = wdata1;
            end else if ((BYPASS != 0) && eff_we0_s && (waddr0 == rd_addr_s[k])) begin
                rd_val_s[k] = wdata0;
            end else begin
                rd_val_s[k] = mem_r[rd_addr_s[k]];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd
            assign rd_data[g*DATA_W +: DATA_W] = rd_val_s[g];
        end
    endgenerate

    assign busy       = (state_r != ST_IDLE);
    assign dump_valid = dump_valid_r;
    assign dump_done  = dump_done_r;
    assign dump_addr  = dump_addr_r;
    assign dump_data  = dump_data_r;

endmodule

// File: tb/tb_mod_register_file_mp.sv
// Randomized bench for mod_register_file_mp against a queue/array reference model;
// a second instance with forwarding disabled shares the same stimulus.
module tb_mod_register_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           reset, hold, we0, we1, clear_req, dump_req;
    logic [AW-1:0]  waddr0, waddr1;
    logic [DW-1:0]  wdata0, wdata1;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_data_nb;
    logic           busy, dump_valid, dump_done;
    logic [AW-1:0]  dump_addr;
    logic [DW-1:0]  dump_data;
    logic           busy_nb, dump_valid_nb, dump_done_nb;
    logic [AW-1:0]  dump_addr_nb;
    logic [DW-1:0]  dump_data_nb;

    always #5 clk = ~clk;

    mod_register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .hold(hold), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .rd_addr(rd_addr), .rd_data(rd_data), .clear_req(clear_req), .dump_req(dump_req),
        .busy(busy), .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    mod_register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .hold(hold), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .clear_req(clear_req), .dump_req(dump_req),
        .busy(busy_nb), .dump_valid(dump_valid_nb), .dump_addr(dump_addr_nb),
        .dump_data(dump_data_nb), .dump_done(dump_done_nb)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of entries, an activity mode with a beat countdown,
    // and a queue of dump beats snapshotted when the dump is accepted.
    logic [DW-1:0]   ref_mem [DEPTH];
    int              mode = 0;          // 0 idle, 1 clearing, 2 dumping
    int              left = 0;
    int              ci   = 0;
    logic [AW+DW-1:0] beat_q [$];
    logic            exp_valid = 1'b0, exp_done = 1'b0;
    logic [AW-1:0]   exp_addr = '0;
    logic [DW-1:0]   exp_data = '0;
    bit              rd_chk = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && mode == 0 && !hold) begin
            if (we1 && waddr1 == a) return wdata1;
            if (we0 && waddr0 == a) return wdata0;
        end
        return ref_mem[a];
    endfunction

    task automatic model_edge();
        logic [AW+DW-1:0] b;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            mode = 0; left = 0;
            beat_q.delete();
            exp_addr = '0; exp_data = '0;
        end else if (mode == 1) begin
            ref_mem[ci] = '0;
            ci++; left--;
            if (left == 0) mode = 0;
        end else if (mode == 2) begin
            b = beat_q.pop_front();
            exp_valid = 1'b1;
            exp_addr  = b[AW+DW-1:DW];
            exp_data  = b[DW-1:0];
            exp_done  = (left == 1);
            left--;
            if (left == 0) mode = 0;
        end else begin
            if (we0 && !hold && waddr0 != 0) ref_mem[waddr0] = wdata0;
            if (we1 && !hold && waddr1 != 0) ref_mem[waddr1] = wdata1;
            if (clear_req) begin
                mode = 1; left = DEPTH; ci = 0;
            end else if (dump_req) begin
                mode = 2; left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    logic [AW-1:0] ia;
                    ia = i[AW-1:0];
                    beat_q.push_back({ia, ref_mem[i]});
                end
            end
        end
    endtask

    // One clock: check reads before the edge, advance the model, check registered outputs.
    task automatic cycle();
        #1;
        if (rd_chk) begin
            for (int k = 0; k < NR; k++) begin
                check_val("rd_byp", rd_data[k*DW +: DW], ref_read(rd_addr[k*AW +: AW], 1'b1));
                check_val("rd_nobyp", rd_data_nb[k*DW +: DW], ref_read(rd_addr[k*AW +: AW], 1'b0));
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        check_val("busy", busy, (mode != 0));
        check_val("busy_nb", busy_nb, (mode != 0));
        check_val("dump_valid", dump_valid, exp_valid);
        check_val("dump_done", dump_done, exp_done);
        check_val("dump_addr", dump_addr, exp_addr);
        check_val("dump_data", dump_data, exp_data);
    endtask

    task automatic idle_in();
        reset = 1'b0; hold = 1'b0; we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        clear_req = 1'b0; dump_req = 1'b0; rd_addr = '0;
    endtask

    initial begin
        int bcnt, dcnt;
        logic [AW-1:0] done_addr;
        logic [AW-1:0] a0, a1;

        idle_in();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        rd_chk = 1'b1;

        // Basic write then read; entry 0 always zero
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        cycle();
        we0 = 1'b0; rd_addr = {5'd0, 5'd5};
        #1;
        check_val("t1_r5", rd_data[31:0], 32'hDEADBEEF);
        check_val("t1_r0", rd_data[63:32], 32'h0);
        cycle();

        // Same-address dual write: lane 1 wins, forwarded only on the bypass instance
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        rd_addr = {5'd7, 5'd7};
        #1;
        check_val("t2_byp", rd_data[31:0], 32'h22);
        check_val("t2_nobyp_old", rd_data_nb[31:0], 32'h0);
        cycle();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check_val("t2_stored", rd_data[31:0], 32'h22);
        check_val("t2_nb_stored", rd_data_nb[63:32], 32'h22);
        cycle();

        // Hold blocks writes; entry 0 ignores writes
        hold = 1'b1; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55;
        cycle();
        hold = 1'b0; we0 = 1'b0;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF;
        rd_addr = {5'd0, 5'd3};
        cycle();
        we1 = 1'b0;
        #1;
        check_val("t3_r3", rd_data[31:0], 32'h0);
        check_val("t3_r0", rd_data[63:32], 32'h0);
        cycle();

        // Fill r1..r31 with their index, then dump
        for (int i = 1; i < DEPTH; i++) begin
            we0 = 1'b1; waddr0 = i[AW-1:0]; wdata0 = i;
            cycle();
        end
        idle_in();
        dump_req = 1'b1;
        cycle();
        dump_req = 1'b0;
        bcnt = busy; dcnt = 0; done_addr = '0;
        for (int i = 0; i < 40; i++) begin
            rd_addr = $urandom;
            cycle();
            bcnt += busy;
            if (dump_done) begin dcnt++; done_addr = dump_addr; end
        end
        check_val("t4_busy_cycles", bcnt, 32);
        check_val("t4_done_count", dcnt, 1);
        check_val("t4_done_addr", done_addr, 5'd31);

        // Clear wins over dump; writes during clear are dropped
        clear_req = 1'b1; dump_req = 1'b1;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hABCD;
        cycle();
        clear_req = 1'b0; dump_req = 1'b0;
        bcnt = busy;
        for (int i = 0; i < 32; i++) begin
            we0 = 1'b1; waddr0 = 5'($urandom_range(1, 31)); wdata0 = $urandom;
            rd_addr = $urandom;
            cycle();
            bcnt += busy;
        end
        we0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            bcnt += busy;
        end
        check_val("t5_busy_cycles", bcnt, 32);
        check_val("t5_no_dump", dump_valid, 1'b0);
        for (int i = 0; i < DEPTH; i += 2) begin
            rd_addr = {5'(i + 1), 5'(i)};
            #1;
            check_val("t5_zero_lo", rd_data[31:0], 32'h0);
            check_val("t5_zero_hi", rd_data[63:32], 32'h0);
            cycle();
        end

        // Reset aborts a dump at beat 10
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h1234;
        cycle();
        we0 = 1'b0; dump_req = 1'b1;
        cycle();
        dump_req = 1'b0;
        for (int i = 0; i < 11; i++) cycle();
        check_val("t6_beat10", dump_addr, 5'd10);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_val("t6_busy", busy, 1'b0);
        check_val("t6_valid", dump_valid, 1'b0);
        rd_addr = {5'd1, 5'd12};
        #1;
        check_val("t6_r12", rd_data[31:0], 32'h0);
        dump_req = 1'b1;
        cycle();
        dump_req = 1'b0;
        check_val("t6_reaccept", busy, 1'b1);
        for (int i = 0; i < 34; i++) cycle();

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            reset     = ($urandom_range(0, 499) == 0);
            hold      = ($urandom_range(0, 7) == 0);
            we0       = $urandom_range(0, 1);
            we1       = $urandom_range(0, 1);
            waddr0    = $urandom;
            waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom);
            wdata0    = $urandom;
            wdata1    = $urandom;
            clear_req = ($urandom_range(0, 199) == 0);
            dump_req  = ($urandom_range(0, 99) == 0);
            a0 = ($urandom_range(0, 1) == 0) ? waddr0 : 5'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? waddr1 : 5'($urandom);
            rd_addr   = {a1, a0};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
